kernel_coeff_buffer: RTL and testbench
======================================

// Module: kernel_coeff_buffer
// PURPOSE
//  Parametrised convolution-kernel coefficient store for the 1D convolution datapath.
//  Loads KERNEL_LEN coefficients through a valid/ready input port.
//  Then replays them endlessly, in order or reversed, through a valid/ready output port.
//  Each output beat carries its tap index and an end-of-pass flag.
//  Sits between the coefficient source and the MAC array; a pulse on load_start reloads it at any time.
// PARAMETERS
//  DATA_W      32  coefficient width, bits
//  KERNEL_LEN  3   number of taps, >=1
//  REVERSE     0   0: replay taps 0..KERNEL_LEN-1; 1: replay KERNEL_LEN-1..0 (flipped kernel)
//  IDX_W       derived: max(1, $clog2(KERNEL_LEN)); not user-set
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-low reset
//  load_start  in   1       pulse: discard contents, restart load phase
//  in_valid    in   1       coefficient beat valid
//  in_data     in   DATA_W  coefficient; beat n is written to tap n
//  in_ready    out  1       buffer accepts a beat (LOAD state and !load_start)
//  out_valid   out  1       out_data/out_tap/out_last valid
//  out_ready   in   1       consumer takes the beat
//  out_data    out  DATA_W  coefficient value
//  out_tap     out  IDX_W   tap index of out_data
//  out_last    out  1       final beat of a replay pass
//  loaded      out  1       all KERNEL_LEN taps written since last reload
// BEHAVIOUR
//  Reset (async, reset=0):
//   - state=LOAD, wr_ptr=0; rd_ptr=0 (REVERSE=0) or KERNEL_LEN-1 (REVERSE=1)
//   - out_valid=0, out_data=0, out_tap=0, out_last=0, loaded=0
//   - in_ready=1 once reset releases (it is combinational on state)
//  Memory: KERNEL_LEN x DATA_W registers; not cleared by reset.
//  in_ready = (state==LOAD) && !load_start.
//  LOAD:
//   - on in_valid&&in_ready: mem[wr_ptr]<=in_data; wr_ptr++
//   - on the beat with wr_ptr==KERNEL_LEN-1: wr_ptr<=0, loaded<=1, state<=RUN
//   - out_valid stays 0 throughout
//  RUN:
//   - output is a single register stage, updated when (!out_valid || out_ready)
//   - the update loads out_data=mem[rd_ptr], out_tap=rd_ptr, out_valid=1,
//     out_last=(rd_ptr==end tap), then advances rd_ptr
//   - end tap is KERNEL_LEN-1 (REVERSE=0) or 0 (REVERSE=1)
//   - first out_valid=1 appears in the 2nd cycle after the last load beat is accepted
//   - with out_ready held 1, one beat per cycle, no bubbles
//   - stall: while out_valid&&!out_ready, out_data/out_tap/out_last hold stable and rd_ptr holds
//   - wrap: REVERSE=0 goes KERNEL_LEN-1 -> 0; REVERSE=1 goes 0 -> KERNEL_LEN-1
//   - in_valid ignored; in_ready=0
//  load_start=1 (any state, highest priority):
//   - next cycle: state=LOAD, wr_ptr=0, rd_ptr=start tap, out_valid=0, out_last=0, loaded=0
//   - an output beat pending that cycle is dropped, even if out_ready=1
//   - no input beat is accepted that cycle
//  KERNEL_LEN=1: every output beat has out_tap=0, out_last=1.
//  Partial load, then load_start: restarts at tap 0; earlier beats are overwritten.
//  No arithmetic on data; pointers are IDX_W bits and compare against KERNEL_LEN-1 explicitly (non-power-of-2 safe).
// TESTING
//  T1 reset: assert reset=0 mid-RUN.
//     -> out_valid=0, loaded=0, in_ready=1 after release; out_data=0
//  T2 load+replay (LEN=3, REVERSE=0): load 0x11,0x22,0x33; out_ready=1.
//     -> 0x11/t0, 0x22/t1, 0x33/t2 (last=1), then 0x11/t0 repeats
//     -> first out_valid exactly 2 cycles after the 0x33 accept
//  T3 backpressure: in RUN, drop out_ready for 4 cycles while out_data=0x22.
//     -> out_data/out_tap/out_last stable; resumes with 0x33; no beat lost or duplicated
//  T4 reverse (REVERSE=1, LEN=3): load 0xA,0xB,0xC.
//     -> 0xC/t2, 0xB/t1, 0xA/t0 (last=1), repeat
//  T5 reload mid-run: load_start while out_valid=1, out_ready=1, with in_valid=1 the same cycle.
//     -> that beat is not accepted; out_valid=0 next cycle
//     -> load 0x5,0x6,0x7 -> replay 0x5,0x6,0x7; no old value appears
//  T6 gaps/LEN=5 non-pow2: load with in_valid toggled randomly.
//     -> exactly 5 beats accepted, then in_ready=0; tap wraps 4->0
//     -> KERNEL_LEN=1 build: out_last=1 every beat

Source files
------------

// File: rtl/kernel_coeff_buffer_if.sv
// kernel_coeff_buffer_if
//   Bundles the load and replay handshakes of kernel_coeff_buffer.
//   Parameters: DATA_W (coefficient width), KERNEL_LEN (tap count).
//   IDX_W is derived here so the tap field width always matches the buffer.
//
//   Handshake rule (both directions): a beat transfers on a rising clk edge
//   where valid && ready. The producer holds valid and its payload stable
//   until that edge. ready may depend on the consumer's state, but never on
//   the same beat's valid.
//
//   Signals
//     load_start  master->slave  pulse: restart the load phase
//     in_valid    master->slave  coefficient beat valid
//     in_data     master->slave  coefficient beat
//     in_ready    slave->master  buffer accepts a coefficient beat
//     out_valid   slave->master  replayed beat valid
//     out_ready   master->slave  consumer takes the replayed beat
//     out_data    slave->master  coefficient value
//     out_tap     slave->master  tap index of out_data
//     out_last    slave->master  final beat of a replay pass
//     loaded      slave->master  all taps written since the last reload
interface kernel_coeff_buffer_if #(
    parameter int DATA_W     = 32,
    parameter int KERNEL_LEN = 3
);
    localparam int IDX_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;

    logic              load_start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_tap;
    logic              out_last;
    logic              loaded;

    modport master (
        output load_start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_tap, out_last, loaded
    );

    modport slave (
        input  load_start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_tap, out_last, loaded
    );
endinterface

// File: rtl/kernel_coeff_buffer.sv
// kernel_coeff_buffer
//   Coefficient store for the 1D convolution datapath. Accepts KERNEL_LEN
//   coefficients (beat n -> tap n), then replays them forever, forward or
//   flipped, each beat tagged with its tap index and an end-of-pass flag.
//   A load_start pulse discards everything and restarts loading at any time.
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous, active-low reset
//     bus        kernel_coeff_buffer_if.slave (load and replay handshakes)
//     state_dbg  current FSM state: 0 = LOAD, 1 = RUN
module kernel_coeff_buffer #(
    parameter int DATA_W     = 32,
    parameter int KERNEL_LEN = 3,
    parameter int REVERSE    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    kernel_coeff_buffer_if.slave bus,
    output logic                 state_dbg
);
    localparam int IDX_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;

    // Pointers are compared against explicit tap numbers so that a
    // non-power-of-two KERNEL_LEN wraps correctly.
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(KERNEL_LEN - 1);
    localparam logic [IDX_W-1:0] START_TAP = (REVERSE != 0) ? LAST_IDX : '0;
    localparam logic [IDX_W-1:0] END_TAP   = (REVERSE != 0) ? '0 : LAST_IDX;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q,     state_d;
    logic [IDX_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [IDX_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [IDX_W-1:0]  out_tap_q,   out_tap_d;
    logic              out_last_q,  out_last_d;
    logic              loaded_q,    loaded_d;
    logic [DATA_W-1:0] mem_q [KERNEL_LEN];
    logic [DATA_W-1:0] mem_d [KERNEL_LEN];

    logic              in_ready_c;
    logic [IDX_W-1:0]  rd_next;

    // load_start gates in_ready so no beat is taken in the reload cycle.
    assign in_ready_c = (state_q == LOAD) && !bus.load_start;

    always_comb begin
        rd_next = rd_ptr_q;
        if (REVERSE != 0) begin
            rd_next = (rd_ptr_q == '0) ? LAST_IDX : rd_ptr_q - 1'b1;
        end else begin
            rd_next = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tap_d   = out_tap_q;
        out_last_d  = out_last_q;
        loaded_d    = loaded_q;
        mem_d       = mem_q;

        if (bus.load_start) begin
            // Highest priority: a pending output beat is dropped even if
            // the consumer is ready this cycle.
            state_d     = LOAD;
            wr_ptr_d    = '0;
            rd_ptr_d    = START_TAP;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            loaded_d    = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.in_valid && in_ready_c) begin
                        mem_d[wr_ptr_q] = bus.in_data;
                        if (wr_ptr_q == LAST_IDX) begin
                            wr_ptr_d = '0;
                            loaded_d = 1'b1;
                            state_d  = RUN;
                        end else begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Single output register: refill when empty or drained.
                    if (!out_valid_q || bus.out_ready) begin
                        out_data_d  = mem_q[rd_ptr_q];
                        out_tap_d   = rd_ptr_q;
                        out_last_d  = (rd_ptr_q == END_TAP);
                        out_valid_d = 1'b1;
                        rd_ptr_d    = rd_next;
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= START_TAP;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tap_q   <= '0;
            out_last_q  <= 1'b0;
            loaded_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tap_q   <= out_tap_d;
            out_last_q  <= out_last_d;
            loaded_q    <= loaded_d;
        end
    end

    // Coefficient storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tap   = out_tap_q;
    assign bus.out_last  = out_last_q;
    assign bus.loaded    = loaded_q;
    assign state_dbg     = (state_q == RUN);
endmodule

// File: tb/tb_kernel_coeff_buffer.sv
`timescale 1ns/1ps
module tb_kernel_coeff_buffer;
    localparam int N = 4;

    // ---------------- clock / reset / shared stimulus ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic load_start = 1'b0;
    logic in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic out_ready = 1'b1;

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Four builds see the same stimulus: a=LEN3 fwd, b=LEN3 rev, c=LEN5 fwd, d=LEN1
    int lens[N] = '{3, 3, 5, 1};
    int revs[N] = '{0, 1, 0, 0};

    kernel_coeff_buffer_if #(.DATA_W(32), .KERNEL_LEN(3)) if_a ();
    kernel_coeff_buffer_if #(.DATA_W(32), .KERNEL_LEN(3)) if_b ();
    kernel_coeff_buffer_if #(.DATA_W(32), .KERNEL_LEN(5)) if_c ();
    kernel_coeff_buffer_if #(.DATA_W(32), .KERNEL_LEN(1)) if_d ();

    assign if_a.load_start = load_start; assign if_a.in_valid = in_valid;
    assign if_a.in_data = in_data;       assign if_a.out_ready = out_ready;
    assign if_b.load_start = load_start; assign if_b.in_valid = in_valid;
    assign if_b.in_data = in_data;       assign if_b.out_ready = out_ready;
    assign if_c.load_start = load_start; assign if_c.in_valid = in_valid;
    assign if_c.in_data = in_data;       assign if_c.out_ready = out_ready;
    assign if_d.load_start = load_start; assign if_d.in_valid = in_valid;
    assign if_d.in_data = in_data;       assign if_d.out_ready = out_ready;

    logic dbg_a, dbg_b, dbg_c, dbg_d;

    kernel_coeff_buffer #(.DATA_W(32), .KERNEL_LEN(3), .REVERSE(0)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a), .state_dbg(dbg_a));
    kernel_coeff_buffer #(.DATA_W(32), .KERNEL_LEN(3), .REVERSE(1)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b), .state_dbg(dbg_b));
    kernel_coeff_buffer #(.DATA_W(32), .KERNEL_LEN(5), .REVERSE(0)) dut_c (
        .clk(clk), .reset(reset), .bus(if_c), .state_dbg(dbg_c));
    kernel_coeff_buffer #(.DATA_W(32), .KERNEL_LEN(1), .REVERSE(0)) dut_d (
        .clk(clk), .reset(reset), .bus(if_d), .state_dbg(dbg_d));

    logic        ov[N];
    logic [31:0] od[N];
    logic [2:0]  ot[N];
    logic        ol[N];
    logic        ld[N];
    logic        ir[N];
    logic        dbg[N];

    assign ov[0] = if_a.out_valid; assign ov[1] = if_b.out_valid;
    assign ov[2] = if_c.out_valid; assign ov[3] = if_d.out_valid;
    assign od[0] = if_a.out_data;  assign od[1] = if_b.out_data;
    assign od[2] = if_c.out_data;  assign od[3] = if_d.out_data;
    assign ot[0] = {1'b0, if_a.out_tap};  assign ot[1] = {1'b0, if_b.out_tap};
    assign ot[2] = if_c.out_tap;          assign ot[3] = {2'b00, if_d.out_tap};
    assign ol[0] = if_a.out_last;  assign ol[1] = if_b.out_last;
    assign ol[2] = if_c.out_last;  assign ol[3] = if_d.out_last;
    assign ld[0] = if_a.loaded;    assign ld[1] = if_b.loaded;
    assign ld[2] = if_c.loaded;    assign ld[3] = if_d.loaded;
    assign ir[0] = if_a.in_ready;  assign ir[1] = if_b.in_ready;
    assign ir[2] = if_c.in_ready;  assign ir[3] = if_d.in_ready;
    assign dbg[0] = dbg_a; assign dbg[1] = dbg_b;
    assign dbg[2] = dbg_c; assign dbg[3] = dbg_d;

    // ---------------- reference model ----------------
    // Tracks the replay stream as a position count: position p of a pass
    // is tap p%LEN (forward) or LEN-1-p%LEN (reverse).
    logic [31:0] m_coef[N][8];
    int          m_wr[N];
    int          m_pos[N];
    logic        m_run[N];
    logic        m_ov[N];
    logic [31:0] m_od[N];
    int          m_ot[N];
    logic        m_ol[N];
    logic        m_ld[N];

    function automatic int stream_tap(input int len, input int rev, input int pos);
        return (rev != 0) ? (len - 1 - (pos % len)) : (pos % len);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                m_run[k] <= 1'b0; m_wr[k] <= 0; m_pos[k] <= 0;
                m_ov[k] <= 1'b0; m_od[k] <= '0; m_ot[k] <= 0;
                m_ol[k] <= 1'b0; m_ld[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load_start) begin
                    m_run[k] <= 1'b0; m_wr[k] <= 0; m_pos[k] <= 0;
                    m_ov[k] <= 1'b0; m_ol[k] <= 1'b0; m_ld[k] <= 1'b0;
                end else if (!m_run[k]) begin
                    if (in_valid) begin
                        m_coef[k][m_wr[k]] <= in_data;
                        if (m_wr[k] == lens[k] - 1) begin
                            m_run[k] <= 1'b1; m_ld[k] <= 1'b1; m_wr[k] <= 0;
                        end else begin
                            m_wr[k] <= m_wr[k] + 1;
                        end
                    end
                end else if (!m_ov[k] || out_ready) begin
                    m_ov[k]  <= 1'b1;
                    m_ot[k]  <= stream_tap(lens[k], revs[k], m_pos[k]);
                    m_od[k]  <= m_coef[k][stream_tap(lens[k], revs[k], m_pos[k])];
                    m_ol[k]  <= ((m_pos[k] % lens[k]) == lens[k] - 1);
                    m_pos[k] <= m_pos[k] + 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        in_valid = 1'b0;
        cyc();
        load_start = 1'b0;
    endtask

    task automatic load3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        in_valid = 1'b1; in_data = a; cyc();
        in_data = b; cyc();
        in_data = c; cyc();
        in_valid = 1'b0; in_data = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        load_start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cyc(); cyc();
        for (int k = 0; k < N; k++) begin
            total++;
            if (ov[k] !== 1'b0) begin bad++; $display("FAIL reset_out_valid dut%0d got=%b exp=0", k, ov[k]); end
            total++;
            if (od[k] !== 32'h0) begin bad++; $display("FAIL reset_out_data dut%0d got=%h exp=0", k, od[k]); end
            total++;
            if (ot[k] !== 3'd0 || ol[k] !== 1'b0) begin
                bad++; $display("FAIL reset_tap_last dut%0d got=%0d/%b exp=0/0", k, ot[k], ol[k]);
            end
            total++;
            if (ld[k] !== 1'b0) begin bad++; $display("FAIL reset_loaded dut%0d got=%b exp=0", k, ld[k]); end
        end
        reset = 1'b1;
        cyc();
        for (int k = 0; k < N; k++) begin
            total++;
            if (ir[k] !== 1'b1) begin bad++; $display("FAIL reset_in_ready dut%0d got=%b exp=1", k, ir[k]); end
            total++;
            if (dbg[k] !== 1'b0) begin bad++; $display("FAIL reset_state dut%0d got=%b exp=0", k, dbg[k]); end
        end
    endtask

    task automatic test_load_replay();
        int tap_a, tap_b;
        out_ready = 1'b1;
        pulse_load_start();
        load3(32'h11, 32'h22, 32'h33);
        // One cycle after the last accept: still no output.
        total++;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL replay_latency_early got=%b exp=0", ov[0]); end
        total++;
        if (ld[0] !== 1'b1) begin bad++; $display("FAIL replay_loaded got=%b exp=1", ld[0]); end
        cyc();
        for (int i = 0; i < 6; i++) begin
            tap_a = i % 3;
            tap_b = 2 - (i % 3);
            total++;
            if (ov[0] !== 1'b1 || od[0] !== 32'h11 * (tap_a + 1) || ot[0] !== 3'(tap_a)
                || ol[0] !== (tap_a == 2)) begin
                bad++;
                $display("FAIL replay_fwd beat%0d got=%b/%h/%0d/%b exp=1/%h/%0d/%b",
                         i, ov[0], od[0], ot[0], ol[0], 32'h11 * (tap_a + 1), tap_a, tap_a == 2);
            end
            total++;
            if (ov[1] !== 1'b1 || od[1] !== 32'h11 * (tap_b + 1) || ot[1] !== 3'(tap_b)
                || ol[1] !== (tap_b == 0)) begin
                bad++;
                $display("FAIL replay_rev beat%0d got=%b/%h/%0d/%b exp=1/%h/%0d/%b",
                         i, ov[1], od[1], ot[1], ol[1], 32'h11 * (tap_b + 1), tap_b, tap_b == 0);
            end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q[$];
        logic        found;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!found && ov[0] === 1'b1 && od[0] === 32'h22) found = 1'b1;
            else if (!found) cyc();
        end
        total++;
        if (!found) begin bad++; $display("FAIL stall_wait got=timeout exp=out_data 22"); end
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++;
            if (ov[0] !== 1'b1 || od[0] !== 32'h22 || ot[0] !== 3'd1 || ol[0] !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cyc%0d got=%b/%h/%0d/%b exp=1/22/1/0", i, ov[0], od[0], ot[0], ol[0]);
            end
        end
        out_ready = 1'b1;
        exp_q = '{32'h33, 32'h11, 32'h22, 32'h33};
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            cyc();
            total++;
            if (ov[0] !== 1'b1 || od[0] !== e) begin
                bad++; $display("FAIL stall_resume got=%b/%h exp=1/%h", ov[0], od[0], e);
            end
        end
    endtask

    task automatic test_reverse();
        int tap;
        out_ready = 1'b1;
        pulse_load_start();
        load3(32'hA, 32'hB, 32'hC);
        total++;
        if (ov[1] !== 1'b0) begin bad++; $display("FAIL reverse_latency got=%b exp=0", ov[1]); end
        cyc();
        for (int i = 0; i < 6; i++) begin
            tap = 2 - (i % 3);
            total++;
            if (ov[1] !== 1'b1 || od[1] !== 32'hA + tap || ot[1] !== 3'(tap) || ol[1] !== (tap == 0)) begin
                bad++;
                $display("FAIL reverse_beat%0d got=%b/%h/%0d/%b exp=1/%h/%0d/%b",
                         i, ov[1], od[1], ot[1], ol[1], 32'hA + tap, tap, tap == 0);
            end
            cyc();
        end
    endtask

    task automatic test_reload_mid_run();
        int tap;
        out_ready = 1'b1;
        total++;
        if (ov[0] !== 1'b1) begin bad++; $display("FAIL reload_pre_valid got=%b exp=1", ov[0]); end
        load_start = 1'b1; in_valid = 1'b1; in_data = 32'h99;
        #1;
        for (int k = 0; k < N; k++) begin
            total++;
            if (ir[k] !== 1'b0) begin bad++; $display("FAIL reload_in_ready dut%0d got=%b exp=0", k, ir[k]); end
        end
        cyc();
        load_start = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            total++;
            if (ov[k] !== 1'b0 || ld[k] !== 1'b0 || dbg[k] !== 1'b0) begin
                bad++; $display("FAIL reload_clear dut%0d got=%b/%b/%b exp=0/0/0", k, ov[k], ld[k], dbg[k]);
            end
        end
        load3(32'h5, 32'h6, 32'h7);
        cyc();
        for (int i = 0; i < 6; i++) begin
            tap = i % 3;
            total++;
            if (ov[0] !== 1'b1 || od[0] !== 32'h5 + tap || ot[0] !== 3'(tap)) begin
                bad++; $display("FAIL reload_replay beat%0d got=%b/%h/%0d exp=1/%h/%0d",
                                i, ov[0], od[0], ot[0], 32'h5 + tap, tap);
            end
            total++;
            if (ov[3] !== 1'b1 || od[3] !== 32'h5 || ot[3] !== 3'd0 || ol[3] !== 1'b1) begin
                bad++; $display("FAIL reload_len1 beat%0d got=%b/%h/%0d/%b exp=1/5/0/1",
                                i, ov[3], od[3], ot[3], ol[3]);
            end
            cyc();
        end
    endtask

    task automatic test_gaps();
        logic [31:0] acc_q[$];
        int cnt, pos, guard;
        out_ready = 1'b1;
        pulse_load_start();
        cnt = 0; guard = 0;
        while (cnt < 5 && guard < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = $urandom;
            if (in_valid && ir[2]) begin
                acc_q.push_back(in_data);
                cnt++;
            end
            cyc();
            guard++;
        end
        in_valid = 1'b0;
        total++;
        if (cnt != 5) begin bad++; $display("FAIL gaps_accept_count got=%0d exp=5", cnt); end
        total++;
        if (ir[2] !== 1'b0 || ld[2] !== 1'b1) begin
            bad++; $display("FAIL gaps_full got=in_ready %b loaded %b exp=0/1", ir[2], ld[2]);
        end
        pos = 0;
        for (int i = 0; i < 40 && acc_q.size() == 5; i++) begin
            cyc();
            total++;
            if (ir[2] !== 1'b0) begin bad++; $display("FAIL gaps_in_ready_run got=%b exp=0", ir[2]); end
            if (ov[2]) begin
                total++;
                if (od[2] !== acc_q[pos % 5] || ot[2] !== 3'(pos % 5) || ol[2] !== ((pos % 5) == 4)) begin
                    bad++; $display("FAIL gaps_stream pos%0d got=%h/%0d/%b exp=%h/%0d/%b",
                                    pos, od[2], ot[2], ol[2], acc_q[pos % 5], pos % 5, (pos % 5) == 4);
                end
            end
            if (ov[3]) begin
                total++;
                if (ot[3] !== 3'd0 || ol[3] !== 1'b1) begin
                    bad++; $display("FAIL gaps_len1_last got=%0d/%b exp=0/1", ot[3], ol[3]);
                end
            end
            in_valid = 1'($urandom_range(0, 1));
            in_data = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            if (ov[2] && out_ready) pos++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (pos <= 5) begin bad++; $display("FAIL gaps_wrap got=%0d beats exp=>5", pos); end
    endtask

    task automatic test_random();
        load_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cyc();
            for (int k = 0; k < N; k++) begin
                total++;
                if (ov[k] !== m_ov[k] || ld[k] !== m_ld[k] || dbg[k] !== m_run[k]
                    || ir[k] !== (!m_run[k] && !load_start)) begin
                    bad++;
                    $display("FAIL rand_ctrl dut%0d cyc%0d got=v%b l%b s%b r%b exp=v%b l%b s%b r%b",
                             k, i, ov[k], ld[k], dbg[k], ir[k], m_ov[k], m_ld[k], m_run[k],
                             !m_run[k] && !load_start);
                end
                if (m_ov[k]) begin
                    total++;
                    if (od[k] !== m_od[k] || ot[k] !== 3'(m_ot[k]) || ol[k] !== m_ol[k]) begin
                        bad++;
                        $display("FAIL rand_beat dut%0d cyc%0d got=%h/%0d/%b exp=%h/%0d/%b",
                                 k, i, od[k], ot[k], ol[k], m_od[k], m_ot[k], m_ol[k]);
                    end
                end
            end
            load_start = ($urandom_range(0, 39) == 0);
            in_valid = 1'($urandom_range(0, 1));
            in_data = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        load_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b1;
        pulse_load_start();
        load3(32'h1, 32'h2, 32'h3);
        cyc(); cyc();
        total++;
        if (ov[0] !== 1'b1) begin bad++; $display("FAIL midreset_pre got=%b exp=1", ov[0]); end
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            total++;
            if (ov[k] !== 1'b0 || ld[k] !== 1'b0 || od[k] !== 32'h0 || ol[k] !== 1'b0) begin
                bad++; $display("FAIL midreset_async dut%0d got=%b/%b/%h/%b exp=0/0/0/0",
                                k, ov[k], ld[k], od[k], ol[k]);
            end
        end
        cyc();
        reset = 1'b1;
        cyc();
        for (int k = 0; k < N; k++) begin
            total++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0) begin
                bad++; $display("FAIL midreset_release dut%0d got=ready %b valid %b exp=1/0", k, ir[k], ov[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_replay();
        test_backpressure();
        test_reverse();
        test_reload_mid_run();
        test_gaps();
        test_random();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
